// File: rtl/lm07_pkg.sv
// Shared definitions for the LM07 temperature display path: FSM states,
// double-dabble iteration count, 7-segment glyphs and digit-select patterns.
package lm07_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One shift per magnitude bit below the pre-loaded MSB.
    localparam int unsigned DD_ITERS = 8;

    // Segment bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Active-low one-hot digit selects.
    localparam logic [3:0] DSEL_OFF  = 4'b1111;
    localparam logic [3:0] DSEL_ONES = 4'b1110;
    localparam logic [3:0] DSEL_TENS = 4'b1101;
    localparam logic [3:0] DSEL_HUND = 4'b1011;
    localparam logic [3:0] DSEL_SIGN = 4'b0111;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'h3F;
            4'd1:    seg_digit = 7'h06;
            4'd2:    seg_digit = 7'h5B;
            4'd3:    seg_digit = 7'h4F;
            4'd4:    seg_digit = 7'h66;
            4'd5:    seg_digit = 7'h6D;
            4'd6:    seg_digit = 7'h7D;
            4'd7:    seg_digit = 7'h07;
            4'd8:    seg_digit = 7'h7F;
            4'd9:    seg_digit = 7'h6F;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 9-bit magnitude to three BCD nibbles, one shift
// per cycle. The magnitude MSB is pre-loaded into the BCD field (a single
// shift of a value below 5 needs no adjust), so eight iterations suffice.
module bin2bcd_seq
    import lm07_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] mag,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [3:0] LAST_ITER = 4'(DD_ITERS - 1);

    logic [11:0] bcd;
    logic [7:0]  bin;
    logic [3:0]  iter;
    logic [11:0] adj;

    // Add 3 to every BCD nibble of 5 or more ahead of the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift once per cycle; done pulses after the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd  <= '0;
            bin  <= '0;
            iter <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd  <= {11'd0, mag[8]};
                bin  <= mag[7:0];
                iter <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                {bcd, bin} <= {adj, bin} << 1;
                iter       <= iter + 4'd1;
                if (iter == LAST_ITER) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

endmodule

// File: rtl/temp_seg_display.sv
// Display stage for the LM07 reader: captures each signed temperature word,
// converts its magnitude to BCD and scans sign/hundreds/tens/ones onto a
// four-digit multiplexed 7-segment display with leading-zero blanking.
module temp_seg_display
    import lm07_pkg::*;
#(
    parameter int REFRESH_DIV = 4
)(
    input  logic       SYSCLK,
    input  logic       RSTN,
    input  logic [7:0] temp_data,
    input  logic       temp_valid,
    output logic [6:0] seg,
    output logic [3:0] dsel,
    output logic       busy,
    output logic [7:0] shown_temp
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    state_t      state;
    logic [7:0]  cand;
    logic [7:0]  pend;
    logic        pend_valid;
    logic        disp_neg;
    logic [3:0]  disp_h, disp_t, disp_o;

    logic        start;
    logic [7:0]  start_word;
    logic [8:0]  mag;
    logic        dd_busy, dd_done;
    logic [3:0]  dd_h, dd_t, dd_o;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       digit_idx;
    logic [6:0]       cur_seg;
    logic [3:0]       cur_dsel;

    // A conversion starts from IDLE on a strobe, or straight out of COMMIT
    // with the newest waiting word (a strobe on the COMMIT edge beats pending).
    always_comb begin
        start      = 1'b0;
        start_word = temp_data;
        case (state)
            ST_IDLE:   start = temp_valid;
            ST_COMMIT: begin
                start      = temp_valid | pend_valid;
                start_word = temp_valid ? temp_data : pend;
            end
            default:   start = 1'b0;
        endcase
    end

    // Magnitude as 9 bits so -128 yields +128.
    assign mag = start_word[7] ? (9'd0 - {1'b1, start_word}) : {1'b0, start_word};

    bin2bcd_seq u_bcd (
        .clk      (SYSCLK),
        .rst_n    (RSTN),
        .start    (start),
        .mag      (mag),
        .busy     (dd_busy),
        .done     (dd_done),
        .hundreds (dd_h),
        .tens     (dd_t),
        .ones     (dd_o)
    );

    // Capture/convert/commit sequencing with a one-deep latest-wins pending slot.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= ST_IDLE;
            cand       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            busy       <= 1'b0;
            disp_neg   <= 1'b0;
            disp_h     <= '0;
            disp_t     <= '0;
            disp_o     <= '0;
            shown_temp <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        cand  <= start_word;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    busy <= 1'b1;
                    if (temp_valid) begin
                        pend       <= temp_data;
                        pend_valid <= 1'b1;
                    end
                    if (dd_done && !dd_busy) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_neg   <= cand[7];
                    disp_h     <= dd_h;
                    disp_t     <= dd_t;
                    disp_o     <= dd_o;
                    shown_temp <= cand;
                    pend_valid <= 1'b0;
                    busy       <= start;
                    if (start) begin
                        cand  <= start_word;
                        state <= ST_CONV;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Glyph and select for the digit currently being scanned, with blanking.
    always_comb begin
        cur_seg  = SEG_BLANK;
        cur_dsel = DSEL_OFF;
        case (digit_idx)
            2'd0: begin
                cur_seg  = seg_digit(disp_o);
                cur_dsel = DSEL_ONES;
            end
            2'd1: begin
                cur_seg  = (disp_h == 4'd0 && disp_t == 4'd0) ? SEG_BLANK : seg_digit(disp_t);
                cur_dsel = DSEL_TENS;
            end
            2'd2: begin
                cur_seg  = (disp_h == 4'd0) ? SEG_BLANK : seg_digit(disp_h);
                cur_dsel = DSEL_HUND;
            end
            default: begin
                cur_seg  = disp_neg ? SEG_MINUS : SEG_BLANK;
                cur_dsel = DSEL_SIGN;
            end
        endcase
    end

    // Refresh divider and digit scan; seg/dsel are registered every cycle.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            div_cnt   <= '0;
            digit_idx <= '0;
            seg       <= SEG_BLANK;
            dsel      <= DSEL_OFF;
        end else begin
            seg  <= cur_seg;
            dsel <= cur_dsel;
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_temp_seg_display.sv
// Bench for temp_seg_display: expected scan output is derived from the
// committed temperature with decimal arithmetic and the cycle count since
// reset release; commit timing follows the strobe-to-display latency.
module tb_temp_seg_display;

    localparam int RD = 4;
    localparam int SCAN = 4 * RD;

    logic       SYSCLK = 1'b0;
    logic       RSTN = 1'b1;
    logic [7:0] temp_data = 8'h00;
    logic       temp_valid = 1'b0;
    logic [6:0] seg;
    logic [3:0] dsel;
    logic       busy;
    logic [7:0] shown_temp;

    int         vectors = 0;
    int         miscompares = 0;
    int         edge_cnt = 0;
    logic [7:0] model_val = 8'h00;

    temp_seg_display #(.REFRESH_DIV(RD)) dut (
        .SYSCLK     (SYSCLK),
        .RSTN       (RSTN),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .seg        (seg),
        .dsel       (dsel),
        .busy       (busy),
        .shown_temp (shown_temp)
    );

    // Clock and reset bookkeeping: count rising edges since reset release.
    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) edge_cnt = 0;
        else       edge_cnt = edge_cnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int scan_pos(input int e);
        return ((e - 1) / RD) % 4;
    endfunction

    function automatic logic [3:0] exp_dsel(input int e);
        logic [3:0] one;
        one = 4'b0001;
        if (e == 0) return 4'b1111;
        return ~(one << scan_pos(e));
    endfunction

    function automatic logic [6:0] exp_seg(input int e, input logic [7:0] w);
        int v, m, h, t, o;
        if (e == 0) return 7'h00;
        v = int'($signed(w));
        m = (v < 0) ? -v : v;
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        case (scan_pos(e))
            0: return digit_seg(o);
            1: return (h == 0 && t == 0) ? 7'h00 : digit_seg(t);
            2: return (h == 0) ? 7'h00 : digit_seg(h);
            default: return (v < 0) ? 7'h40 : 7'h00;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RSTN = 1'b1;
        temp_valid = 1'b0;
        #2 RSTN = 1'b0;
        repeat (3) @(negedge SYSCLK);
        vectors++;
        if ({seg, dsel, busy, shown_temp} !== {7'h00, 4'b1111, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state seg=%h dsel=%b busy=%b shown=%h exp seg=00 dsel=1111 busy=0 shown=00",
                     seg, dsel, busy, shown_temp);
        end
        RSTN = 1'b1;
        model_val = 8'h00;
        for (int k = 1; k <= 2 * SCAN; k++) begin
            @(negedge SYSCLK);
            vectors++;
            if (k == 1 && (dsel !== 4'b1110 || seg !== 7'h3F)) begin
                miscompares++;
                $display("FAIL first_edge dsel=%b seg=%h exp dsel=1110 seg=3f", dsel, seg);
            end
            vectors++;
            if (dsel !== exp_dsel(edge_cnt) || seg !== exp_seg(edge_cnt, 8'h00) ||
                busy !== 1'b0 || shown_temp !== 8'h00) begin
                miscompares++;
                $display("FAIL idle_scan k=%0d dsel=%b seg=%h busy=%b shown=%h exp dsel=%b seg=%h busy=0 shown=00",
                         k, dsel, seg, busy, shown_temp, exp_dsel(edge_cnt), exp_seg(edge_cnt, 8'h00));
            end
        end
    endtask

    task automatic test_convert(input logic [7:0] w);
        logic [7:0] prev, disp, exp_shown;
        logic       exp_busy;
        prev = model_val;
        @(negedge SYSCLK);
        temp_data  = w;
        temp_valid = 1'b1;
        for (int k = 0; k <= 10 + SCAN; k++) begin
            @(negedge SYSCLK);
            temp_valid = 1'b0;
            temp_data  = 8'($urandom_range(0, 255));
            exp_busy   = (k >= 1 && k <= 9);
            exp_shown  = (k >= 10) ? w : prev;
            disp       = (k >= 11) ? w : prev;
            vectors++;
            if (busy !== exp_busy || shown_temp !== exp_shown) begin
                miscompares++;
                $display("FAIL convert_%h k=%0d busy=%b shown=%h exp busy=%b shown=%h",
                         w, k, busy, shown_temp, exp_busy, exp_shown);
            end
            vectors++;
            if (dsel !== exp_dsel(edge_cnt) || seg !== exp_seg(edge_cnt, disp)) begin
                miscompares++;
                $display("FAIL scan_%h k=%0d dsel=%b seg=%h exp dsel=%b seg=%h",
                         w, k, dsel, seg, exp_dsel(edge_cnt), exp_seg(edge_cnt, disp));
            end
        end
        model_val = w;
    endtask

    // Strobe w1 at N, optional w_mid at N+dm (dm=0: none), w2 at N+d2 (1..10).
    // w1 commits at N+10, w2 at N+20; w_mid is overwritten and never shown.
    task automatic test_back_to_back(input logic [7:0] w1, input logic [7:0] w_mid,
                                     input int dm, input logic [7:0] w2, input int d2);
        logic [7:0] prev, disp, exp_shown;
        logic       exp_busy;
        prev = model_val;
        @(negedge SYSCLK);
        temp_data  = w1;
        temp_valid = 1'b1;
        for (int k = 0; k <= 21 + SCAN; k++) begin
            @(negedge SYSCLK);
            exp_busy  = (k >= 1 && k <= 19);
            exp_shown = (k >= 20) ? w2 : (k >= 10) ? w1 : prev;
            disp      = (k >= 21) ? w2 : (k >= 11) ? w1 : prev;
            vectors++;
            if (busy !== exp_busy || shown_temp !== exp_shown) begin
                miscompares++;
                $display("FAIL b2b_%h_%h k=%0d busy=%b shown=%h exp busy=%b shown=%h",
                         w1, w2, k, busy, shown_temp, exp_busy, exp_shown);
            end
            vectors++;
            if (dsel !== exp_dsel(edge_cnt) || seg !== exp_seg(edge_cnt, disp)) begin
                miscompares++;
                $display("FAIL b2b_scan k=%0d dsel=%b seg=%h exp dsel=%b seg=%h",
                         k, dsel, seg, exp_dsel(edge_cnt), exp_seg(edge_cnt, disp));
            end
            temp_valid = 1'b0;
            temp_data  = 8'($urandom_range(0, 255));
            if (dm != 0 && k + 1 == dm) begin
                temp_valid = 1'b1;
                temp_data  = w_mid;
            end
            if (k + 1 == d2) begin
                temp_valid = 1'b1;
                temp_data  = w2;
            end
        end
        model_val = w2;
    endtask

    task automatic test_reset_mid();
        @(negedge SYSCLK);
        temp_data  = 8'h64;
        temp_valid = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge SYSCLK);
            temp_valid = 1'b0;
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy busy=%b exp 1", busy);
        end
        RSTN = 1'b0;
        #1;
        vectors++;
        if ({seg, dsel, busy, shown_temp} !== {7'h00, 4'b1111, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL async_reset seg=%h dsel=%b busy=%b shown=%h exp seg=00 dsel=1111 busy=0 shown=00",
                     seg, dsel, busy, shown_temp);
        end
        @(negedge SYSCLK);
        RSTN = 1'b1;
        model_val = 8'h00;
        for (int k = 1; k <= 2 * SCAN; k++) begin
            @(negedge SYSCLK);
            vectors++;
            if (dsel !== exp_dsel(edge_cnt) || seg !== exp_seg(edge_cnt, 8'h00) ||
                busy !== 1'b0 || shown_temp !== 8'h00) begin
                miscompares++;
                $display("FAIL after_reset k=%0d dsel=%b seg=%h busy=%b shown=%h exp dsel=%b seg=%h busy=0 shown=00",
                         k, dsel, seg, busy, shown_temp, exp_dsel(edge_cnt), exp_seg(edge_cnt, 8'h00));
            end
        end
    endtask

    initial begin
        int d2, dm;
        test_reset();
        test_convert(8'h19);
        test_convert(8'hD8);
        test_convert(8'h80);
        test_convert(8'h7F);
        test_convert(8'h00);
        test_convert(8'h9C);
        repeat (6) test_convert(8'($urandom_range(0, 255)));
        test_back_to_back(8'h05, 8'h0A, 2, 8'h14, 4);
        test_back_to_back(8'h21, 8'h00, 0, 8'hE7, 3);
        test_back_to_back(8'hF6, 8'h33, 9, 8'h63, 10);
        repeat (4) begin
            d2 = $urandom_range(1, 10);
            dm = (d2 > 1) ? $urandom_range(0, d2 - 1) : 0;
            test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), dm,
                              8'($urandom_range(0, 255)), d2);
        end
        test_reset_mid();
        test_convert(8'hC4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
